// File: rtl/mandelbrot_pixel_packer.sv
// Pixel stream packer for the Mandelbrot engine.
// Tracks the raster position of each incoming pixel, packs two 4-bit pixels into
// one byte, and queues the bytes in a small FIFO that drains over a valid/ready
// interface. Each queued byte carries start-of-frame and end-of-line tags.
// The engine cannot be stalled, so a byte that finds the FIFO full is dropped
// and a sticky overrun flag is raised.
module mandelbrot_pixel_packer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       running,
    input  logic       new_ctr,
    input  logic [3:0] ctr_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic       out_eol,
    output logic       overrun,
    output logic       frame_done
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic          running_q;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    held;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [9:0]    mem [FIFO_DEPTH];

    logic          frame_start;
    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic          empty;
    logic          full;
    logic          pop;
    logic          odd_px;
    logic          push;
    logic          drop;
    logic [9:0]    entry;
    logic [9:0]    head;

    // Decode the current pixel position, FIFO status and push/pop decisions.
    always_comb begin
        frame_start = running & ~running_q;
        // A strobe coinciding with the frame start is already pixel (0,0).
        x_cur  = frame_start ? '0 : x;
        y_cur  = frame_start ? '0 : y;
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop    = ~empty & out_ready;
        odd_px = new_ctr & x_cur[0];
        // A full FIFO still accepts the byte when the head leaves in the same cycle.
        push   = odd_px & (~full | pop);
        drop   = odd_px & full & ~pop;
        entry  = {(x_cur == XW'(1)) && (y_cur == '0), x_cur == X_LAST, ctr_in, held};
        head   = mem[rd_ptr[AW-1:0]];
    end

    // Drive the byte interface from the FIFO head; payload is forced low while empty.
    always_comb begin
        out_valid = ~empty;
        out_data  = out_valid ? head[7:0] : 8'h00;
        out_sof   = out_valid & head[9];
        out_eol   = out_valid & head[8];
    end

    // Raster position, nibble holding, FIFO pointers and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_q  <= 1'b0;
            x          <= '0;
            y          <= '0;
            held       <= 4'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            running_q  <= running;
            frame_done <= new_ctr && (x_cur == X_LAST) && (y_cur == Y_LAST);

            if (new_ctr) begin
                if (x_cur == X_LAST) begin
                    x <= '0;
                    y <= (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
                end else begin
                    x <= x_cur + XW'(1);
                    y <= y_cur;
                end
            end else if (frame_start) begin
                x <= '0;
                y <= '0;
            end

            if (new_ctr && !x_cur[0]) begin
                held <= ctr_in;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            // A drop in the frame-start cycle belongs to the new frame, so it wins.
            if (frame_start) begin
                overrun <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr[AW-1:0]] <= entry;
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_packer.sv
// Bench for mandelbrot_pixel_packer with a small 4x2 raster and an 8-byte FIFO.
// A queue-based reference model follows the pixel stream by linear pixel index.
module tb_mandelbrot_pixel_packer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 8;

    logic       clk;
    logic       reset;
    logic       running;
    logic       new_ctr;
    logic [3:0] ctr_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eol;
    logic       overrun;
    logic       frame_done;

    mandelbrot_pixel_packer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .running(running), .new_ctr(new_ctr),
        .ctr_in(ctr_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
        .overrun(overrun), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: pixel index within frame, held nibble, byte queue.
    int         m_p;
    logic [3:0] m_held;
    logic [9:0] mq[$];
    bit         m_ovr;
    bit         m_fd;
    bit         m_runq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(bit rst, bit run, bit nc, logic [3:0] c, bit rdy);
        bit   pop;
        bit   full;
        int   px;
        int   py;
        if (rst) begin
            mq.delete();
            m_p = 0; m_held = 4'h0; m_ovr = 0; m_fd = 0; m_runq = 0;
            return;
        end
        if (run && !m_runq) begin
            m_p = 0;
            m_ovr = 0;
        end
        m_runq = run;
        full = (mq.size() == D);
        pop = (mq.size() != 0) && rdy;
        m_fd = 0;
        if (pop) void'(mq.pop_front());
        if (nc) begin
            px = m_p % W;
            py = m_p / W;
            if (px % 2 == 0) begin
                m_held = c;
            end else if (!full || pop) begin
                mq.push_back({(px == 1 && py == 0), (px == W - 1), c, m_held});
            end else begin
                m_ovr = 1;
            end
            m_fd = (m_p == W * H - 1);
            m_p = (m_p + 1) % (W * H);
        end
    endfunction

    task automatic check_model();
        check("m_valid", out_valid, mq.size() != 0);
        check("m_overrun", overrun, m_ovr);
        check("m_frame_done", frame_done, m_fd);
        if (mq.size() != 0) begin
            check("m_data", out_data, mq[0][7:0]);
            check("m_sof", out_sof, mq[0][9]);
            check("m_eol", out_eol, mq[0][8]);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic cyc(input bit rst, input bit run, input bit nc, input logic [3:0] c, input bit rdy);
        reset = rst; running = run; new_ctr = nc; ctr_in = c; out_ready = rdy;
        model_step(rst, run, nc, c, rdy);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         run;
        bit         nc;
        logic [3:0] c;
        bit         rdy;
        bit         v;
        logic [7:0] d;
        bit         sof;
        bit         eol;
        bit         fd;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int cnt;
        bit rrun;

        // Directed vectors: first byte of a frame, then a full 4x2 frame.
        tbl[0]  = '{1, 1, 4'h3, 0, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{1, 1, 4'hA, 0, 1, 8'hA3, 1, 0, 0};
        tbl[2]  = '{1, 0, 4'h0, 1, 0, 8'h00, 0, 0, 0};
        tbl[3]  = '{0, 0, 4'h0, 1, 0, 8'h00, 0, 0, 0};
        tbl[4]  = '{1, 1, 4'h0, 1, 0, 8'h00, 0, 0, 0};
        tbl[5]  = '{1, 1, 4'h1, 1, 1, 8'h10, 1, 0, 0};
        tbl[6]  = '{1, 1, 4'h2, 1, 0, 8'h00, 0, 0, 0};
        tbl[7]  = '{1, 1, 4'h3, 1, 1, 8'h32, 0, 1, 0};
        tbl[8]  = '{1, 1, 4'h4, 1, 0, 8'h00, 0, 0, 0};
        tbl[9]  = '{1, 1, 4'h5, 1, 1, 8'h54, 0, 0, 0};
        tbl[10] = '{1, 1, 4'h6, 1, 0, 8'h00, 0, 0, 0};
        tbl[11] = '{1, 1, 4'h7, 1, 1, 8'h76, 0, 1, 1};
        tbl[12] = '{1, 0, 4'h0, 1, 0, 8'h00, 0, 0, 0};

        reset = 1; running = 0; new_ctr = 0; ctr_in = 0; out_ready = 0;

        // Reset state
        cyc(1, 0, 0, 4'h0, 0);
        cyc(1, 0, 0, 4'h0, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eol", out_eol, 0);
        cyc(0, 0, 0, 4'h0, 0);

        for (int i = 0; i < 13; i++) begin
            cyc(0, tbl[i].run, tbl[i].nc, tbl[i].c, tbl[i].rdy);
            check("tbl_valid", out_valid, tbl[i].v);
            check("tbl_frame_done", frame_done, tbl[i].fd);
            if (tbl[i].v) begin
                check("tbl_data", out_data, tbl[i].d);
                check("tbl_sof", out_sof, tbl[i].sof);
                check("tbl_eol", out_eol, tbl[i].eol);
            end
        end

        // Overflow: 18 pixels with the sink stalled, then drain in order.
        cyc(0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 18; i++) cyc(0, 1, 1, 4'(i), 0);
        check("ovf_overrun", overrun, 1);
        for (int k = 0; k < 8; k++) begin
            check("ovf_drain_valid", out_valid, 1);
            check("ovf_drain_data", out_data, {4'(2 * k + 1), 4'(2 * k)});
            cyc(0, 1, 0, 4'h0, 1);
        end
        check("ovf_empty", out_valid, 0);
        check("ovf_sticky", overrun, 1);
        cyc(0, 0, 0, 4'h0, 0);
        cyc(0, 1, 0, 4'h0, 0);
        check("ovf_cleared", overrun, 0);

        // Full FIFO with a simultaneous pop and push.
        for (int i = 0; i < 16; i++) cyc(0, 1, 1, 4'(i + 3), 0);
        cyc(0, 1, 1, 4'hC, 0);
        cyc(0, 1, 1, 4'hD, 1);
        check("full_pp_overrun", overrun, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) cnt++;
            cyc(0, 1, 0, 4'h0, 1);
        end
        check("full_pp_occupancy", cnt, 8);

        // Reset mid-frame discards held nibble and queued bytes.
        cyc(0, 0, 0, 4'h0, 0);
        cyc(0, 1, 1, 4'h1, 0);
        cyc(0, 1, 1, 4'h2, 0);
        cyc(0, 1, 1, 4'h3, 0);
        cyc(1, 0, 0, 4'h0, 0);
        check("midrst_valid", out_valid, 0);
        cyc(0, 1, 1, 4'h5, 0);
        check("midrst_first_valid", out_valid, 0);
        cyc(0, 1, 1, 4'h6, 0);
        check("midrst_valid2", out_valid, 1);
        check("midrst_data", out_data, 8'h65);
        check("midrst_sof", out_sof, 1);
        cyc(0, 1, 0, 4'h0, 1);
        check("midrst_no_stale", out_valid, 0);

        // Randomized traffic against the model, light then heavy backpressure.
        rrun = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) rrun = ~rrun;
            cyc($urandom_range(0, 249) == 0, rrun, $urandom_range(0, 2) != 0,
                4'($urandom), (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
